// File: rtl/ipm_distributed_sync_fifo_v1_3_pkg.sv
// ipm_distributed_sync_fifo_v1_3_pkg: shared sizing helpers and read-mode constants for the distributed sync FIFO
package ipm_distributed_sync_fifo_v1_3_pkg;
  localparam int FWFT_STD = 0;
  localparam int FWFT_ON = 1;
  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/ipm_distributed_sync_fifo_v1_3_if.sv
// ipm_distributed_sync_fifo_v1_3_if: write/read handshake and status bundle of the sync FIFO
interface ipm_distributed_sync_fifo_v1_3_if
  import ipm_distributed_sync_fifo_v1_3_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_full;
  logic almost_full;
  logic overflow;
  logic rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic rd_empty;
  logic almost_empty;
  logic underflow;
  logic [cnt_width(ADDR_WIDTH)-1:0] data_count;
  modport master (
    output wr_en, wr_data, rd_en,
    input wr_full, almost_full, overflow, rd_data, rd_empty, almost_empty, underflow, data_count
  );
  modport slave (
    input wr_en, wr_data, rd_en,
    output wr_full, almost_full, overflow, rd_data, rd_empty, almost_empty, underflow, data_count
  );
endinterface

// File: rtl/ipm_distributed_sdpram_v1_3.sv
// ipm_distributed_sdpram_v1_3: single-clock LUT RAM, synchronous write, asynchronous read with optional output register
module ipm_distributed_sdpram_v1_3
  import ipm_distributed_sync_fifo_v1_3_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] rd_q;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_q <= '0;
    else if (rd_en) rd_q <= mem[rd_addr];
  // RAM contents survive reset; only the output register is cleared
  assign rd_data = OUT_REG ? rd_q : mem[rd_addr];
endmodule

// File: rtl/ipm_distributed_sync_fifo_v1_3.sv
// ipm_distributed_sync_fifo_v1_3: single-clock FIFO on LUT RAM with count, almost flags, error pulses and optional FWFT
module ipm_distributed_sync_fifo_v1_3
  import ipm_distributed_sync_fifo_v1_3_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT = 0,
  parameter int ALMOST_FULL_NUM = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_NUM = 2
) (
  input logic clk,
  input logic rst,
  ipm_distributed_sync_fifo_v1_3_if.slave fifo
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(ALMOST_FULL_NUM);
  localparam logic [CW-1:0] AE_C = CW'(ALMOST_EMPTY_NUM);
  if (ADDR_WIDTH < 4 || ADDR_WIDTH > 10 || DATA_WIDTH < 1 || DATA_WIDTH > 256 ||
      (FWFT != FWFT_STD && FWFT != FWFT_ON) ||
      ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH ||
      ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_param_err
    $error("ipm_distributed_sync_fifo_v1_3: parameter out of legal range");
  end
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  logic [CW-1:0] cnt_nxt;
  // accept decisions use only the registered flags, so a read never frees a slot for a same-cycle write
  assign wr_acc = fifo.wr_en & ~fifo.wr_full;
  assign rd_acc = fifo.rd_en & ~fifo.rd_empty;
  assign cnt_nxt = fifo.data_count + CW'(wr_acc) - CW'(rd_acc);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo.data_count <= '0;
      fifo.wr_full <= 1'b0;
      fifo.almost_full <= 1'b0;
      fifo.rd_empty <= 1'b1;
      fifo.almost_empty <= 1'b1;
      fifo.overflow <= 1'b0;
      fifo.underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
      fifo.data_count <= cnt_nxt;
      fifo.wr_full <= cnt_nxt == DEPTH_C;
      fifo.almost_full <= cnt_nxt >= AF_C;
      fifo.rd_empty <= cnt_nxt == '0;
      fifo.almost_empty <= cnt_nxt <= AE_C;
      fifo.overflow <= fifo.wr_en & fifo.wr_full;
      fifo.underflow <= fifo.rd_en & fifo.rd_empty;
    end
  ipm_distributed_sdpram_v1_3 #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_REG(FWFT == FWFT_STD)
  ) u_ram (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_acc),
    .wr_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data(fifo.wr_data),
    .rd_en(rd_acc),
    .rd_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data(fifo.rd_data)
  );
endmodule

// File: tb/tb_ipm_distributed_sync_fifo_v1_3.sv
// tb_ipm_distributed_sync_fifo_v1_3: standard and FWFT instances driven in lockstep against a queue model
module tb_ipm_distributed_sync_fifo_v1_3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ipm_distributed_sync_fifo_v1_3_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) si ();
  ipm_distributed_sync_fifo_v1_3_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) fi ();
  assign fi.wr_en = si.wr_en;
  assign fi.wr_data = si.wr_data;
  assign fi.rd_en = si.rd_en;
  ipm_distributed_sync_fifo_v1_3 #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .fifo(si)
  );
  ipm_distributed_sync_fifo_v1_3 #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .fifo(fi)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a 16-entry queue; standard read data is the last word popped
  logic [7:0] q[$];
  logic [7:0] m_rd = 8'h00;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      m_rd = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      int n;
      n = q.size();
      m_ovf = si.wr_en && n == 16;
      m_unf = si.rd_en && n == 0;
      if (si.rd_en && n != 0) m_rd = q.pop_front();
      if (si.wr_en && n != 16) q.push_back(si.wr_data);
    end
  always @(negedge clk) begin
    chk("count", 32'(si.data_count), q.size());
    chk("full", 32'(si.wr_full), 32'(q.size() == 16));
    chk("empty", 32'(si.rd_empty), 32'(q.size() == 0));
    chk("afull", 32'(si.almost_full), 32'(q.size() >= 14));
    chk("aempty", 32'(si.almost_empty), 32'(q.size() <= 2));
    chk("overflow", 32'(si.overflow), 32'(m_ovf));
    chk("underflow", 32'(si.underflow), 32'(m_unf));
    chk("rd_data", 32'(si.rd_data), 32'(m_rd));
    chk("f_count", 32'(fi.data_count), q.size());
    chk("f_empty", 32'(fi.rd_empty), 32'(q.size() == 0));
    if (q.size() != 0) chk("f_rd_data", 32'(fi.rd_data), 32'(q[0]));
  end
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
    si.wr_en = we;
    si.wr_data = wd;
    si.rd_en = re;
    @(posedge clk);
    #1;
    si.wr_en = 1'b0;
    si.rd_en = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] prev;
    si.wr_en = 1'b0;
    si.wr_data = 8'h00;
    si.rd_en = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(si.data_count), 0);
    chk("rst_empty", 32'(si.rd_empty), 1);
    chk("rst_aempty", 32'(si.almost_empty), 1);
    chk("rst_full", 32'(si.wr_full), 0);
    chk("rst_rd_data", 32'(si.rd_data), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      chk("fill_afull", 32'(si.almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_count", 32'(si.data_count), 16);
    chk("fill_full", 32'(si.wr_full), 1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_data", 32'(si.rd_data), i);
    end
    chk("drain_empty", 32'(si.rd_empty), 1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", 32'(si.overflow), 1);
    chk("ovf_count", 32'(si.data_count), 16);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", 32'(si.overflow), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("ovf_drain", 32'(si.rd_data), 32'h10 + i);
    end
    prev = si.rd_data;
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_pulse", 32'(si.underflow), 1);
    chk("unf_hold", 32'(si.rd_data), 32'h1F);
    chk("unf_hold_prev", 32'(si.rd_data), 32'(prev));
    chk("unf_count", 32'(si.data_count), 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("unf_clear", 32'(si.underflow), 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h45 + i), 1'b1);
      chk("wr_rd_data", 32'(si.rd_data), 32'h40 + i);
      chk("wr_rd_count", 32'(si.data_count), 5);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("tail_data", 32'(si.rd_data), 32'h68 + i);
    end
    cyc(1'b1, 8'h5C, 1'b0);
    chk("fwft_empty", 32'(fi.rd_empty), 0);
    chk("fwft_data", 32'(fi.rd_data), 32'h5C);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", 32'(fi.rd_empty), 1);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    chk("burst_count", 32'(si.data_count), 9);
    si.wr_en = 1'b1;
    si.wr_data = 8'h99;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(si.data_count), 0);
    chk("arst_empty", 32'(si.rd_empty), 1);
    chk("arst_aempty", 32'(si.almost_empty), 1);
    chk("arst_rd_data", 32'(si.rd_data), 0);
    chk("arst_f_empty", 32'(fi.rd_empty), 1);
    si.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 8'h33, 1'b0);
    chk("post_rst_fwft", 32'(fi.rd_data), 32'h33);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_data", 32'(si.rd_data), 32'h33);
    chk("post_rst_empty", 32'(si.rd_empty), 1);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
